// File: rtl/byte_striping_nlane_pkg.sv
// Shared constants and helpers for the N-lane byte striper.
// Lane-pointer width and partial-group valid mask live here so top and bench agree.
package byte_striping_pkg;

   localparam logic [7:0] INACTIVE_DEF = 8'h00;
   localparam logic [7:0] PAD_DEF      = 8'h00;

   // Pointer width for n lanes; a single lane still needs a 1-bit register.
   function automatic int ptr_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Mask with the low c bits set: lanes 0..c-1 carry staged words.
   function automatic logic [7:0] lane_mask(input int unsigned c);
      return 8'((16'd1 << c) - 16'd1);
   endfunction

endpackage

// File: rtl/byte_striping_nlane_if.sv
// Handshake/data bundle between the TX word source and the per-lane serialisers.
interface byte_striping_nlane_if #(
   parameter int N_LANES = 4,
   parameter int DATA_W  = 8
);
   logic                        enb;
   logic                        tx_ValidE;
   logic [DATA_W-1:0]           tx_DataE;
   logic [N_LANES*DATA_W-1:0]   tx_lanes;
   logic [N_LANES-1:0]          tx_lane_valid;
   logic                        tx_group_stb;

   modport master (
      output enb, tx_ValidE, tx_DataE,
      input  tx_lanes, tx_lane_valid, tx_group_stb
   );

   modport slave (
      input  enb, tx_ValidE, tx_DataE,
      output tx_lanes, tx_lane_valid, tx_group_stb
   );
endinterface

// File: rtl/byte_striping_nlane_stripe_lane_reg.sv
// One lane of the striper: a staging register plus the registered lane output.
// DIRECT lanes take the incoming word on emit instead of their staging register.
module stripe_lane_reg #(
   parameter int                DATA_W   = 8,
   parameter logic [DATA_W-1:0] INACTIVE = '0,
   parameter logic [DATA_W-1:0] PAD      = '0,
   parameter bit                DIRECT   = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              emit,
   input  logic              pad,
   input  logic [DATA_W-1:0] word,
   output logic [DATA_W-1:0] lane
);

   logic [DATA_W-1:0] stage;

   always_ff @(posedge clk) begin
      if (rst) begin
         stage <= '0;
         lane  <= INACTIVE;
      end else begin
         if (load)
            stage <= word;
         if (pad)
            lane <= PAD;
         else if (emit)
            lane <= DIRECT ? word : stage;
      end
   end

endmodule

// File: rtl/byte_striping_nlane.sv
// Round-robin striper of a serial word stream across N_LANES lanes, released a group at a time.
// Optional STRIPE_FLUSH_EN: an idle cycle with a partial group pending emits it padded.
module byte_striping_nlane
   import byte_striping_pkg::*;
#(
   parameter int                N_LANES  = 4,
   parameter int                DATA_W   = 8,
   parameter logic [DATA_W-1:0] INACTIVE = DATA_W'(INACTIVE_DEF),
   parameter logic [DATA_W-1:0] PAD      = DATA_W'(PAD_DEF)
) (
   input  logic                  clk,
   input  logic                  rst,
   byte_striping_nlane_if.slave  bus
);

   localparam int             CW   = ptr_w(N_LANES);
   localparam logic [CW-1:0]  LAST = CW'(N_LANES - 1);

   logic [CW-1:0]             cnt;
   logic                      accept;
   logic                      emit_grp;
   logic                      flush;
   logic                      stb;
   logic [N_LANES-1:0]        valid;
   logic [N_LANES*DATA_W-1:0] lanes;

   assign accept   = bus.enb && bus.tx_ValidE;
   assign emit_grp = accept && (cnt == LAST);

`ifdef STRIPE_FLUSH_EN
   assign flush = bus.enb && !bus.tx_ValidE && (cnt != '0);
`else
   assign flush = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (emit_grp || flush)
         cnt <= '0;
      else if (accept)
         cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stb   <= 1'b0;
         valid <= '0;
      end else begin
         stb <= emit_grp || flush;
         if (emit_grp)
            valid <= '1;
         else if (flush)
            valid <= N_LANES'(lane_mask(32'(cnt)));
      end
   end

   for (genvar k = 0; k < N_LANES; k++) begin : g_lane
      logic load_k;
      logic emit_k;
      logic pad_k;

      // On flush, lanes below the pointer hold staged words; the rest are padded.
      assign load_k = accept && !emit_grp && (cnt == CW'(k));
      assign emit_k = emit_grp || (flush && (CW'(k) < cnt));
      assign pad_k  = flush && (CW'(k) >= cnt);

      stripe_lane_reg #(
         .DATA_W   (DATA_W),
         .INACTIVE (INACTIVE),
         .PAD      (PAD),
         .DIRECT   (k == N_LANES - 1)
      ) u_lane (
         .clk  (clk),
         .rst  (rst),
         .load (load_k),
         .emit (emit_k),
         .pad  (pad_k),
         .word (bus.tx_DataE),
         .lane (lanes[k*DATA_W +: DATA_W])
      );
   end

   assign bus.tx_lanes      = lanes;
   assign bus.tx_lane_valid = valid;
   assign bus.tx_group_stb  = stb;

endmodule

// File: tb/tb_byte_striping_nlane.sv
// Scoreboard bench for byte_striping_nlane: a word-queue model predicts each group,
// a monitor compares every strobe and checks that outputs hold between groups.
module tb_byte_striping_nlane;

   localparam int             N    = 4;
   localparam int             W    = 8;
   localparam logic [W-1:0]   INA  = 8'h00;
   localparam logic [W-1:0]   PADV = 8'h00;

   typedef struct {
      logic [N*W-1:0] lanes;
      logic [N-1:0]   valid;
   } grp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   byte_striping_nlane_if #(.N_LANES(N), .DATA_W(W)) bus ();

   byte_striping_nlane #(
      .N_LANES  (N),
      .DATA_W   (W),
      .INACTIVE (INA),
      .PAD      (PADV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   grp_t         exp_q[$];
   logic [W-1:0] pend[$];
   int           errors = 0;
   int           checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Release whatever is pending as one group; missing words become PAD.
   task automatic model_emit();
      grp_t g;
      for (int i = 0; i < N; i++) begin
         g.lanes[i*W +: W] = (i < pend.size()) ? pend[i] : PADV;
         g.valid[i]        = (i < pend.size());
      end
      pend.delete();
      exp_q.push_back(g);
   endtask

   task automatic model_step(input logic r, input logic e, input logic v, input logic [W-1:0] d);
      if (r)
         pend.delete();
      else if (e && v) begin
         pend.push_back(d);
         if (pend.size() == N)
            model_emit();
      end
`ifdef STRIPE_FLUSH_EN
      else if (e && !v && pend.size() != 0)
         model_emit();
`endif
   endtask

   task automatic cycle(input logic r, input logic e, input logic v, input logic [W-1:0] d);
      @(negedge clk);
      rst           = r;
      bus.enb       = e;
      bus.tx_ValidE = v;
      bus.tx_DataE  = d;
      model_step(r, e, v, d);
   endtask

   task automatic word(input logic [W-1:0] d);
      cycle(1'b0, 1'b1, 1'b1, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
   endtask

   task automatic freeze(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
   endtask

   // Monitor: inputs are driven on negedge, so at posedge+1 rst shows what the edge sampled.
   initial begin
      logic [N*W-1:0] ref_l;
      logic [N-1:0]   ref_v;
      grp_t           g;
      ref_l = {N{INA}};
      ref_v = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst === 1'b1) begin
            chk("rst_lanes", 64'(bus.tx_lanes), 64'({N{INA}}));
            chk("rst_valid", 64'(bus.tx_lane_valid), 64'(0));
            chk("rst_stb",   64'(bus.tx_group_stb), 64'(0));
            ref_l = {N{INA}};
            ref_v = '0;
         end else begin
            chk("stb", 64'(bus.tx_group_stb), 64'(exp_q.size() != 0));
            if (bus.tx_group_stb === 1'b1 && exp_q.size() != 0) begin
               g = exp_q.pop_front();
               chk("grp_lanes", 64'(bus.tx_lanes), 64'(g.lanes));
               chk("grp_valid", 64'(bus.tx_lane_valid), 64'(g.valid));
               ref_l = g.lanes;
               ref_v = g.valid;
            end else begin
               if (exp_q.size() != 0)
                  void'(exp_q.pop_front());
               chk("hold_lanes", 64'(bus.tx_lanes), 64'(ref_l));
               chk("hold_valid", 64'(bus.tx_lane_valid), 64'(ref_v));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      bus.enb       = 1'b0;
      bus.tx_ValidE = 1'b0;
      bus.tx_DataE  = '0;
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, 8'h00);

      // Continuous group
      word(8'h11); word(8'h22); word(8'h33); word(8'h44);
      idle(3);
      // Gaps between words
      word(8'h11); idle(1); word(8'h22); idle(2); word(8'h33); word(8'h44);
      idle(2);
      // Freeze mid-group
      word(8'h11); word(8'h22); freeze(3); word(8'h33); word(8'h44);
      idle(2);
      // Reset mid-group
      word(8'h11); word(8'h22);
      cycle(1'b1, 1'b1, 1'b1, 8'h99);
      word(8'h55); word(8'h66); word(8'h77); word(8'h88);
      idle(2);
      // Back-to-back groups
      for (int i = 1; i <= 8; i++)
         word(8'(i));
      idle(2);
      // Partial group followed by idle
      word(8'hA1); word(8'hA2); idle(3);
      cycle(1'b1, 1'b0, 1'b0, 8'h00);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(0, 63) == 0),
               1'($urandom_range(0, 7) != 0),
               1'($urandom_range(0, 3) != 0),
               8'($urandom_range(0, 255)));
      end

      freeze(3);
      chk("drain", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
